// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single-ported 32-bit memory between requester 1 (instruction
// fetch) and requester 2 (load/store unit).
//
// A granted access occupies the memory for MEM_LATENCY cycles (BUSY). The
// read data is then registered and a one-cycle ack goes to the winner (DONE).
// After that the block returns to IDLE, where requests are sampled again.
//
// Build option (macro): ARB_ROUND_ROBIN_EN
//   defined   : on a tie, the requester that did not win the previous grant wins
//   undefined : fixed priority, requester 2 always beats requester 1
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req1/req2, we1/we2           requests and write enables
//   addr1/addr2, wdata1/wdata2   per-requester address and write data
//   ack1/ack2                    one-cycle completion pulse to the winner
//   rdata                        registered read data, valid with ack
//   selector                     mux select (0 = requester 1, 1 = requester 2)
//   mem_en, mem_we               memory strobe and write enable
//   mem_addr, mem_wdata          muxed address and write data
//   mem_rdata                    memory read data
//   busy                         high whenever the block is not IDLE
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req1,
  input  logic        req2,
  input  logic        we1,
  input  logic        we2,
  input  logic [31:0] addr1,
  input  logic [31:0] addr2,
  input  logic [31:0] wdata1,
  input  logic [31:0] wdata2,
  output logic        ack1,
  output logic        ack2,
  output logic [31:0] rdata,
  output logic        selector,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] COUNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic        selector_q, selector_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack1_q, ack1_d;
  logic        ack2_q, ack2_d;
  logic        winner;  // 0 = requester 1, 1 = requester 2

`ifdef ARB_ROUND_ROBIN_EN
  // Identity of the last granted requester; resets to requester 2 so the
  // first tie goes to requester 1.
  logic last_q, last_d;

  always_comb begin
    if (req1 && req2) winner = ~last_q;
    else              winner = req2;
  end
`else
  // Fixed priority: a pending load/store always wins.
  always_comb winner = req2;
`endif

  always_comb begin
    state_d    = state_q;
    selector_d = selector_q;
    count_d    = count_q;
    rdata_d    = rdata_q;
    ack1_d     = 1'b0;
    ack2_d     = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req1 || req2) begin
          state_d    = BUSY;
          selector_d = winner;
          count_d    = COUNT_LOAD;
`ifdef ARB_ROUND_ROBIN_EN
          last_d     = winner;
`endif
        end
      end
      BUSY: begin
        if (count_q == 4'd0) begin
          // Last memory cycle: data is valid now, ack is issued next cycle.
          rdata_d = mem_rdata;
          ack1_d  = ~selector_q;
          ack2_d  = selector_q;
          state_d = DONE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;  // requests are deliberately ignored here
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      selector_q <= 1'b0;
      count_q    <= 4'd0;
      rdata_q    <= 32'd0;
      ack1_q     <= 1'b0;
      ack2_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      selector_q <= selector_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      ack1_q     <= ack1_d;
      ack2_q     <= ack2_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  // Strobes are decoded straight from the state register. The muxes follow
  // the registered selector in every state.
  assign mem_en    = (state_q == BUSY);
  assign mem_we    = mem_en & (selector_q ? we2 : we1);
  assign mem_addr  = selector_q ? addr2 : addr1;
  assign mem_wdata = selector_q ? wdata2 : wdata1;
  assign busy      = (state_q != IDLE);
  assign selector  = selector_q;
  assign ack1      = ack1_q;
  assign ack2      = ack2_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req1, req2, we1, we2;
  logic [31:0] addr1, addr2, wdata1, wdata2, mem_rdata;
  logic        ack1, ack2, selector, mem_en, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;

  logic        sw_reset;
  logic        sw_req;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_winner = 2;  // model of the last-grant pointer (1 or 2)

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req1(req1), .req2(req2), .we1(we1), .we2(we2),
    .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
    .ack1(ack1), .ack2(ack2), .rdata(rdata), .selector(selector),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Latency sweep: two extra instances with requester 1 held continuously.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int SL = (gi == 0) ? 1 : 15;
    logic        s_ack1, s_ack2, s_sel, s_en, s_we, s_busy;
    logic [31:0] s_rdata, s_addr, s_wdata;
    int          last_ack = -1;
    int          n_acks = 0;

    mem_port_arbiter #(.MEM_LATENCY(SL)) u_sweep (
      .clk(clk), .reset(sw_reset),
      .req1(sw_req), .req2(1'b0), .we1(1'b0), .we2(1'b0),
      .addr1(32'h0000_0100), .addr2(32'h0), .wdata1(32'h0), .wdata2(32'h0),
      .ack1(s_ack1), .ack2(s_ack2), .rdata(s_rdata), .selector(s_sel),
      .mem_en(s_en), .mem_we(s_we), .mem_addr(s_addr),
      .mem_wdata(s_wdata), .mem_rdata(32'h0), .busy(s_busy)
    );

    initial begin
      forever begin
        @(negedge clk);
        if (!sw_reset && (s_ack1 || s_ack2)) begin
          check($sformatf("sweep%0d_no_ack2", SL), 32'(s_ack2), 32'd0);
          if (last_ack >= 0)
            check($sformatf("sweep%0d_spacing", SL), 32'(cyc - last_ack), 32'(SL + 2));
          last_ack = cyc;
          n_acks++;
        end
      end
    end
  end

  // Grant rule taken from the arbitration policy, not from the RTL.
  function automatic int pick(input bit r1, input bit r2);
`ifdef ARB_ROUND_ROBIN_EN
    if (r1 && r2) return (last_winner == 2) ? 1 : 2;
`endif
    return r2 ? 2 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle in which requester w gets the grant. Walks the
  // BUSY period, the ack cycle and the following IDLE cycle, then drops req_w.
  task automatic do_access(input int w, input bit use_fixed, input logic [31:0] fixed_rd);
    logic [31:0] ea, ed, exp_rd;
    logic        ew;
    ea = (w == 2) ? addr2 : addr1;
    ed = (w == 2) ? wdata2 : wdata1;
    ew = (w == 2) ? we2 : we1;
    exp_rd = 32'd0;
    last_winner = w;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      check("busy_in_access", 32'(busy), 32'd1);
      check("mem_en_busy", 32'(mem_en), 32'd1);
      check("sel_busy", 32'(selector), 32'(w - 1));
      check("mem_addr", mem_addr, ea);
      check("mem_we", 32'(mem_we), 32'(ew));
      check("mem_wdata", mem_wdata, ed);
      check("no_ack_busy", 32'({ack2, ack1}), 32'd0);
      mem_rdata = (use_fixed && k == LAT) ? fixed_rd : $urandom;
      if (k == LAT) exp_rd = mem_rdata;
    end
    tick();
    check("ack1", 32'(ack1), 32'(w == 1));
    check("ack2", 32'(ack2), 32'(w == 2));
    check("rdata", rdata, exp_rd);
    check("mem_en_done", 32'(mem_en), 32'd0);
    check("mem_we_done", 32'(mem_we), 32'd0);
    check("sel_done", 32'(selector), 32'(w - 1));
    check("mem_addr_done", mem_addr, ea);
    $display("txn grant=%0d addr=%h we=%0d wdata=%h rdata=%h", w, ea, ew, ed, rdata);
    tick();
    check("idle_after", 32'(busy), 32'd0);
    check("no_ack_idle", 32'({ack2, ack1}), 32'd0);
    if (w == 1) req1 = 1'b0;
    else        req2 = 1'b0;
  endtask

  task automatic trial(input bit r1, input bit r2, input bit w1, input bit w2,
                       input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input bit use_fixed, input logic [31:0] fixed_rd);
    tick();
    check("idle_before", 32'(busy), 32'd0);
    req1 = r1; req2 = r2; we1 = w1; we2 = w2;
    addr1 = a1; addr2 = a2; wdata1 = d1; wdata2 = d2;
    while (req1 || req2) do_access(pick(req1, req2), use_fixed, fixed_rd);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_sel"}, 32'(selector), 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_acks"}, 32'({ack2, ack1}), 32'd0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    int exp_w;
    reset = 1'b1; sw_reset = 1'b1; sw_req = 1'b0;
    req1 = 0; req2 = 0; we1 = 0; we2 = 0;
    addr1 = 0; addr2 = 0; wdata1 = 0; wdata2 = 0; mem_rdata = 0;
    tick(); tick();
    check_reset_state("reset");
    reset = 1'b0; sw_reset = 1'b0; sw_req = 1'b1;
    last_winner = 2;
    tick();
    check_reset_state("after_reset");

    // Both requests held continuously for four accesses.
    req1 = 1; req2 = 1; addr1 = 32'h10; addr2 = 32'h20;
    for (int i = 0; i < 4; i++) begin
      exp_w = pick(1'b1, 1'b1);
      last_winner = exp_w;
      n = 0;
      while (!(ack1 || ack2) && n < 50) begin tick(); n++; end
      check("hold_ack_seen", 32'(ack1 | ack2), 32'd1);
      check("hold_order", ack2 ? 32'd2 : 32'd1, 32'(exp_w));
      $display("txn hold grant=%0d expected=%0d", ack2 ? 2 : 1, exp_w);
      tick();
    end
    req1 = 0; req2 = 0;
    tick();
    check("hold_released", 32'(busy), 32'd0);

    // Single fetch and single store.
    trial(1, 0, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0051_3093);
    trial(0, 1, 0, 1, 32'h0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0);

    // Randomized request mixes.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("gap_idle", 32'({busy, ack2, ack1}), 32'd0);
      end
      trial(r[0], r[1], 1'($urandom), 1'($urandom), $urandom, $urandom,
            $urandom, $urandom, 1'b0, 32'h0);
    end

    // Reset in the second BUSY cycle of a requester-2 access.
    tick();
    req2 = 1; we2 = 0; addr2 = 32'h0000_2000;
    tick();
    check("rst_mid_busy1", 32'(busy), 32'd1);
    mem_rdata = 32'hCAFE_F00D;
    tick();
    reset = 1'b1; req2 = 1'b0;
    tick();
    check_reset_state("mid_reset");
    reset = 1'b0;
    last_winner = 2;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_ack_after_reset", 32'({ack2, ack1}), 32'd0);
    end

    check("sweep1_acks_seen", 32'(g_sweep[0].n_acks >= 3), 32'd1);
    check("sweep15_acks_seen", 32'(g_sweep[1].n_acks >= 3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
